// File: rtl/enable_load_sequencer_ctrl_pkg.sv
// Shared encodings and bus helpers for the enable/load sequencer.
package enable_load_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOAD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_REPEAT  = 1'b1;

  // Upper bounds for the generic limit extractor; callers truncate the result.
  localparam int LIM_BUS_MAX  = 1024;
  localparam int NB_TIMER_MAX = 32;

  function automatic logic [NB_TIMER_MAX-1:0] limit_at(
    input logic [LIM_BUS_MAX-1:0] bus,
    input int unsigned            k,
    input int unsigned            nb
  );
    logic [LIM_BUS_MAX-1:0] sh;
    sh       = bus >> (k * nb);
    limit_at = sh[NB_TIMER_MAX-1:0] & ((NB_TIMER_MAX'(1) << nb) - NB_TIMER_MAX'(1));
  endfunction

endpackage

// File: rtl/enable_load_sequencer_ctrl_step_timer.sv
// Per-step cycle counter; flags the last enable cycle of the active step.
module step_timer #(
  parameter int NB_TIMER = 6
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_valid,
  input  logic                i_clear,
  input  logic                i_enable,
  input  logic [NB_TIMER-1:0] i_limit,
  output logic                o_done
);

  logic [NB_TIMER-1:0] timer;

  // Clear is not gated by i_valid so that abort can reach the counter.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)                  timer <= '0;
    else if (i_clear)             timer <= '0;
    else if (i_valid && i_enable) timer <= timer + NB_TIMER'(1);
  end

  assign o_done = (timer == (i_limit - NB_TIMER'(1)));

endmodule

// File: rtl/enable_load_sequencer_ctrl.sv
// Multi-step enable/load sequencer with repeat, abort and zero-length step skip.
module enable_load_sequencer_ctrl
  import enable_load_seq_pkg::*;
#(
  parameter int N_STEPS      = 8,
  parameter int LOG2_N_STEPS = 3,
  parameter int NB_TIMER     = 6,
  parameter int NB_REPEAT    = 4,
  parameter int NB_STATE     = 2
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         i_valid,
  input  logic                         i_trigger,
  input  logic                         i_abort,
  input  logic                         i_mode,
  input  logic [NB_REPEAT-1:0]         i_n_repeat,
  input  logic [N_STEPS*NB_TIMER-1:0]  i_limit_time_bus,
  output logic [N_STEPS-1:0]           o_enable_bus,
  output logic [N_STEPS-1:0]           o_load_bus,
  output logic [LOG2_N_STEPS-1:0]      o_step_idx,
  output logic                         o_busy,
  output logic                         o_done,
  output logic [NB_STATE-1:0]          o_state
);

  state_t                       state;
  logic [LOG2_N_STEPS-1:0]      idx;
  logic [LOG2_N_STEPS-1:0]      idx_nxt;
  logic [NB_REPEAT-1:0]         pass_cnt;
  logic [NB_REPEAT-1:0]         n_rep_sh;
  logic                         mode_sh;
  logic [N_STEPS*NB_TIMER-1:0]  lim_sh;
  logic [N_STEPS-1:0][NB_TIMER-1:0] lim;
  logic                         t_done;
  logic                         t_clear;
  logic                         last_step;
  logic                         more_pass;

  for (genvar k = 0; k < N_STEPS; k++) begin : g_lim
    assign lim[k] = NB_TIMER'(limit_at(LIM_BUS_MAX'(lim_sh), k, NB_TIMER));
  end

  assign idx_nxt   = idx + LOG2_N_STEPS'(1);
  assign last_step = (idx == LOG2_N_STEPS'(N_STEPS - 1));
  assign more_pass = (mode_sh == MODE_REPEAT) &&
                     ((n_rep_sh == '0) || (pass_cnt < n_rep_sh));

  // Timer restarts on every step entry: trigger acceptance and each load.
  assign t_clear = i_abort ||
                   (i_valid && (((state == ST_IDLE) && i_trigger) || (state == ST_LOAD)));

  step_timer #(.NB_TIMER(NB_TIMER)) u_step_timer (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_valid  (i_valid),
    .i_clear  (t_clear),
    .i_enable (state == ST_RUN),
    .i_limit  (lim[idx]),
    .o_done   (t_done)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state    <= ST_IDLE;
      idx      <= '0;
      pass_cnt <= '0;
      lim_sh   <= '0;
      mode_sh  <= MODE_ONESHOT;
      n_rep_sh <= '0;
    end else if (i_abort) begin
      state    <= ST_IDLE;
      idx      <= '0;
      pass_cnt <= '0;
    end else if (i_valid) begin
      case (state)
        ST_IDLE: if (i_trigger) begin
          lim_sh   <= i_limit_time_bus;
          mode_sh  <= i_mode;
          n_rep_sh <= i_n_repeat;
          idx      <= '0;
          pass_cnt <= '0;
          state    <= (i_limit_time_bus[NB_TIMER-1:0] == '0) ? ST_LOAD : ST_RUN;
        end
        ST_RUN: if (t_done) state <= ST_LOAD;
        ST_LOAD: begin
          if (!last_step) begin
            idx   <= idx_nxt;
            state <= (lim[idx_nxt] == '0) ? ST_LOAD : ST_RUN;
          end else if (more_pass) begin
            // Saturate so an endless run never wraps into a finite count.
            if (pass_cnt != '1) pass_cnt <= pass_cnt + NB_REPEAT'(1);
            idx   <= '0;
            state <= (lim[0] == '0) ? ST_LOAD : ST_RUN;
          end else begin
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < N_STEPS; k++) begin : g_out
    assign o_enable_bus[k] = (state == ST_RUN)  && (idx == LOG2_N_STEPS'(k));
    assign o_load_bus[k]   = (state == ST_LOAD) && (idx == LOG2_N_STEPS'(k));
  end

  assign o_step_idx = idx;
  assign o_busy     = (state == ST_RUN) || (state == ST_LOAD);
  assign o_done     = (state == ST_DONE);
  assign o_state    = NB_STATE'(state);

endmodule

// File: doc/enable_load_sequencer_ctrl.md
Name: enable_load_sequencer_ctrl

Overview:
- Parametrised multi-step enable/load sequencer.
- On a trigger it walks a configurable number of steps. Each step holds a one-hot enable for a programmable number of valid cycles, then emits a one-cycle one-hot load pulse for that step.
- Adds limit latching, zero-length step skipping, repeat mode, abort, and busy/done status.
- Sits in the datapath control stack. It drives staged register enables and loads, for example in the multi-cycle GHASH/AES pipelines.

Parameters:
- N_STEPS, 8, number of steps; must be >= 2.
- LOG2_N_STEPS, 3, width of the step index; must satisfy 2^LOG2_N_STEPS >= N_STEPS.
- NB_TIMER, 6, width of each per-step limit and of the step timer.
- NB_REPEAT, 4, width of the repeat count.
- NB_STATE, 2, state width; fixed at 2 and exposed only for routing to the stack.

Ports:
- i_clock  in  1  single clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_valid  in  1  clock enable; when low, every register holds (abort excepted).
- i_trigger  in  1  start request; sampled only in IDLE with i_valid=1.
- i_abort  in  1  synchronous cancel; not gated by i_valid.
- i_mode  in  1  0 = one-shot, 1 = repeat.
- i_n_repeat  in  NB_REPEAT  extra passes in repeat mode; 0 = run until abort.
- i_limit_time_bus  in  N_STEPS*NB_TIMER  per-step enable length in valid cycles; step k occupies bits [k*NB_TIMER +: NB_TIMER].
- o_enable_bus  out  N_STEPS  one-hot enable for the active step.
- o_load_bus  out  N_STEPS  one-hot load pulse for the active step.
- o_step_idx  out  LOG2_N_STEPS  current step index.
- o_busy  out  1  high in RUN or LOAD.
- o_done  out  1  high in DONE.
- o_state  out  NB_STATE  raw state, routed to the stack.

Behaviour:
- Reset (async, i_reset=1):
  - state=IDLE; step index, timer and pass counter = 0; limit and mode shadows = 0.
  - All outputs 0.
- States: IDLE=0, RUN=1, LOAD=2, DONE=3. All outputs are decoded from registers only (Moore).
- Trigger acceptance (IDLE, i_valid=1, i_trigger=1):
  - Latch i_limit_time_bus, i_mode and i_n_repeat into shadows.
  - Step index := 0, timer := 0.
  - Next state = LOAD if limit[0]==0, else RUN.
- RUN:
  - o_enable_bus[idx]=1.
  - Each valid cycle the timer increments.
  - When timer == limit[idx]-1, next state is LOAD.
  - Net effect: enable is high for exactly limit[idx] valid cycles.
- LOAD:
  - o_load_bus[idx]=1 for one valid cycle; timer := 0.
  - If idx < N_STEPS-1: idx := idx+1; next = LOAD if that step's limit is 0, else RUN.
  - If idx == N_STEPS-1 and mode=1 with (n_repeat==0, or passes done < n_repeat): count the pass; idx := 0; re-enter step 0 under the same zero-limit rule.
  - Otherwise (idx == N_STEPS-1, no further pass): next = DONE.
- DONE:
  - o_done=1 for one valid cycle, then IDLE.
  - A trigger in DONE is ignored.
- Trigger in RUN, LOAD or DONE is ignored; no queueing.
- Changes to i_limit_time_bus, i_mode or i_n_repeat mid-sequence have no effect; only the shadows are used.
- i_abort=1 in any state:
  - Next clock: IDLE, idx/timer/pass counter = 0, no o_done.
  - Abort overrides a simultaneous trigger.
- i_valid=0:
  - Registers freeze and outputs hold their level.
  - Consumers must qualify o_load_bus and o_done with i_valid.
- Timer width: limit = 2^NB_TIMER-1 is legal. The compare uses NB_TIMER bits and the counter never wraps within a step.
- Repeat counter saturates and does not wrap. n_repeat==0 in repeat mode means infinite passes.

Decomposition:
- Package enable_load_seq_pkg:
  - State encodings ST_IDLE, ST_RUN, ST_LOAD, ST_DONE.
  - Mode constants MODE_ONESHOT=0, MODE_REPEAT=1.
  - Helper function extracting limit k from the bus.
- One sub-module, step_timer:
  - NB_TIMER counter with clear, enable and valid inputs.
  - Outputs a done flag when timer == limit-1.

Test Plan (N_STEPS=4, NB_TIMER=4, limits {s0=3, s1=1, s2=0, s3=2}, i_valid=1 unless stated):
- One-shot, trigger at cycle 0 -> enable[0] cycles 1-3; load[0] cycle 4; enable[1] cycle 5; load[1] cycle 6; load[2] cycle 7 (skipped step); enable[3] cycles 8-9; load[3] cycle 10; o_done cycle 11; IDLE cycle 12.
- Repeat mode, n_repeat=1 -> two full passes; o_done at cycle 21; exactly 8 load pulses; o_busy continuous from cycles 1-20.
- Abort at cycle 5 -> cycle 6 IDLE with all outputs 0 and no o_done; a new trigger at cycle 6 restarts from step 0.
- i_valid low for cycles 2-4 -> enable[0] held, timer frozen; load[0] moves to cycle 7; remaining schedule shifts by 3.
- Change limits to all 1 at cycle 2 -> schedule unchanged (shadows used); the next trigger uses the new limits.
- Async reset asserted mid-RUN between clock edges -> outputs 0 immediately; state IDLE.
